// File: rtl/mmio_uart_pkg.sv
// Shared register map, bit positions and UART state encoding for the MMIO UART.
package mmio_uart_pkg;

    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_RXDATA = 4'h4;
    localparam logic [3:0] UART_STATUS = 4'h8;
    localparam logic [3:0] UART_CTRL   = 4'hC;

    localparam int unsigned ST_TX_FULL   = 0;
    localparam int unsigned ST_TX_EMPTY  = 1;
    localparam int unsigned ST_RX_EMPTY  = 2;
    localparam int unsigned ST_RX_FULL   = 3;
    localparam int unsigned ST_TX_BUSY   = 4;
    localparam int unsigned ST_OVERRUN   = 5;
    localparam int unsigned ST_FRAME_ERR = 6;
    localparam int unsigned ST_W         = 7;

    localparam int unsigned CTRL_TX_EN    = 0;
    localparam int unsigned CTRL_RX_EN    = 1;
    localparam int unsigned CTRL_IRQ_EN   = 2;
    localparam int unsigned CTRL_LOOPBACK = 3;
    localparam int unsigned CTRL_CLR_OVR  = 5;
    localparam int unsigned CTRL_CLR_FERR = 6;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/mmio_uart_ctrl_sync_fifo.sv
// Synchronous FIFO with a combinational head; pops on empty are refused.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A push racing a refused pop on an empty FIFO is dropped with it.
    assign do_push = push & ~(pop & empty) & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// Memory-mapped UART: buffered TX/RX, sticky errors, loopback and level interrupt.
module mmio_uart_ctrl
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [3:0]       offset;
    logic             wr_txdata, rd_rxdata, wr_ctrl;
    logic [3:0]       ctrl;
    logic             overrun, frame_err;
    logic [ST_W-1:0]  status;
    logic [7:0]       tx_head, rx_head;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic             unused_bits;

    uart_state_t      tx_state, rx_state;
    logic [CNT_W-1:0] tx_cnt, rx_cnt;
    logic [2:0]       tx_idx, rx_idx;
    logic [7:0]       tx_shift, rx_shift;
    logic             tx_bit, tx_bit_end, tx_pop;
    logic             rx_s1, rx_s2, rx_prev, rx_in;
    logic             rx_bit_end, rx_stop_done, rx_push, overrun_set, ferr_set;

    assign unused_bits = &{1'b0, address[1:0], write_data[31:8]};

    // Bus decode; the low two address bits are don't-care.
    assign offset    = {address[3:2], 2'b00};
    assign hit       = (address[31:4] == BASE_ADDR[31:4]);
    assign wr_txdata = mem_write & hit & (offset == UART_TXDATA);
    assign wr_ctrl   = mem_write & hit & (offset == UART_CTRL);
    assign rd_rxdata = mem_read & hit & (offset == UART_RXDATA) & ~rx_empty;

    always_comb begin
        status               = '0;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_RX_EMPTY]  = rx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_TX_BUSY]   = (tx_state != IDLE);
        status[ST_OVERRUN]   = overrun;
        status[ST_FRAME_ERR] = frame_err;
    end

    always_comb begin
        read_data = '0;
        if (hit) begin
            case (offset)
                UART_RXDATA: if (!rx_empty) read_data = {23'b0, 1'b1, rx_head};
                UART_STATUS: read_data = 32'(status);
                UART_CTRL:   read_data = {28'b0, ctrl};
                default:     read_data = '0;
            endcase
        end
    end

    assign irq = ctrl[CTRL_IRQ_EN] & (~rx_empty | overrun | frame_err);
    assign tx  = tx_bit | ctrl[CTRL_LOOPBACK];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(wr_txdata), .pop(tx_pop),
        .din(write_data[7:0]), .head(tx_head), .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rd_rxdata),
        .din(rx_shift), .head(rx_head), .full(rx_full), .empty(rx_empty)
    );

    // Control register and sticky flags; a set event beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl      <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= write_data[3:0];
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (wr_ctrl && write_data[CTRL_CLR_OVR]) begin
                overrun <= 1'b0;
            end
            if (ferr_set) begin
                frame_err <= 1'b1;
            end else if (wr_ctrl && write_data[CTRL_CLR_FERR]) begin
                frame_err <= 1'b0;
            end
        end
    end

    assign tx_bit_end = (tx_cnt == BIT_LAST);
    assign tx_pop     = ctrl[CTRL_TX_EN] & ~tx_empty &
                        ((tx_state == IDLE) | ((tx_state == STOP) & tx_bit_end));

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_bit   <= 1'b1;
        end else begin
            if (tx_state == IDLE || tx_bit_end) begin
                tx_cnt <= '0;
            end else begin
                tx_cnt <= tx_cnt + CNT_W'(1);
            end
            case (tx_state)
                IDLE: begin
                    tx_bit <= 1'b1;
                    if (tx_pop) begin
                        tx_shift <= tx_head;
                        tx_bit   <= 1'b0;
                        tx_state <= START;
                    end
                end
                START: if (tx_bit_end) begin
                    tx_idx   <= '0;
                    tx_bit   <= tx_shift[0];
                    tx_state <= DATA;
                end
                DATA: if (tx_bit_end) begin
                    if (tx_idx == 3'd7) begin
                        tx_bit   <= 1'b1;
                        tx_state <= STOP;
                    end else begin
                        tx_idx   <= tx_idx + 3'd1;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= tx_shift[1];
                    end
                end
                STOP: if (tx_bit_end) begin
                    // Chain straight into the next start bit when data is queued.
                    if (tx_pop) begin
                        tx_shift <= tx_head;
                        tx_bit   <= 1'b0;
                        tx_state <= START;
                    end else begin
                        tx_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign rx_in = ctrl[CTRL_LOOPBACK] ? tx_bit : rx_s2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_in;
        end
    end

    assign rx_bit_end   = (rx_cnt == BIT_LAST);
    assign rx_stop_done = (rx_state == STOP) & rx_bit_end;
    assign rx_push      = rx_stop_done & rx_in & ~rx_full;
    assign overrun_set  = rx_stop_done & rx_in & rx_full;
    assign ferr_set     = rx_stop_done & ~rx_in;

    // Receiver: half-bit start qualification, then whole-bit steps to each mid-bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                IDLE: begin
                    rx_cnt <= '0;
                    if (ctrl[CTRL_RX_EN] && rx_prev && !rx_in) begin
                        rx_state <= START;
                    end
                end
                START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_in ? IDLE : DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_in, rx_shift[7:1]};
                        if (rx_idx == 3'd7) begin
                            rx_state <= STOP;
                        end else begin
                            rx_idx <= rx_idx + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_state <= IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed bench for mmio_uart_ctrl with 4 clocks per bit and 4-deep FIFOs.
module tb_mmio_uart_ctrl;

    localparam int unsigned CPB = 4;
    localparam logic [31:0] A_TX   = 32'h0000_0400;
    localparam logic [31:0] A_RX   = 32'h0000_0404;
    localparam logic [31:0] A_ST   = 32'h0000_0408;
    localparam logic [31:0] A_CTRL = 32'h0000_040C;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        hit;
    logic        rx;
    logic        tx;
    logic        irq;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    mmio_uart_ctrl #(
        .BASE_ADDR(32'h0000_0400),
        .FIFO_DEPTH(4),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
        .address(address), .write_data(write_data), .read_data(read_data),
        .hit(hit), .rx(rx), .tx(tx), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [31:0] addr, output logic [31:0] data);
        address = addr;
        #1;
        data = read_data;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        address    = addr;
        write_data = data;
        mem_write  = 1'b1;
        tick();
        mem_write  = 1'b0;
        address    = A_ST;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        address  = addr;
        mem_read = 1'b1;
        #1;
        data = read_data;
        tick();
        mem_read = 1'b0;
        address  = A_ST;
    endtask

    // Expects one full frame on tx starting at the next clock edge.
    task automatic expect_frame(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < int'(10 * CPB); i++) begin
            tick();
            check($sformatf("tx_%02h_bit%0d", b, i / int'(CPB)), 32'(tx), 32'(f[i / int'(CPB)]));
        end
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop_bit;
        repeat (CPB) tick();
    endtask

    initial begin
        reset      = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        address    = A_ST;
        write_data = '0;
        rx         = 1'b1;

        // Reset state and address decode
        repeat (2) tick();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        peek(A_ST, rd);
        check("rst_status", rd, 32'h0000_0006);
        peek(32'h0000_040A, rd);
        check("status_low_bits_ignored", rd, 32'h0000_0006);
        check("hit_in_window", 32'(hit), 32'd1);
        peek(32'h0000_0410, rd);
        check("hit_above_window", 32'(hit), 32'd0);
        check("rd_outside_window", rd, 32'h0);
        reset = 1'b1;
        address = A_ST;
        tick();

        // Single TX frame of 0xA5: 0,1,0,1,0,0,1,0,1,1
        bus_write(A_CTRL, 32'h1);
        peek(A_CTRL, rd);
        check("ctrl_readback", rd, 32'h1);
        bus_write(A_TX, 32'hA5);
        check("tx_idle_before_pop", 32'(tx), 32'd1);
        expect_frame(8'hA5);
        peek(A_ST, rd);
        check("busy_at_39", 32'(rd[4]), 32'd1);
        tick();
        peek(A_ST, rd);
        check("busy_drop_at_40", 32'(rd[4]), 32'd0);

        // Overfill TX FIFO while disabled, then drain back-to-back
        bus_write(A_CTRL, 32'h0);
        bus_write(A_TX, 32'h11);
        bus_write(A_TX, 32'h22);
        bus_write(A_TX, 32'h33);
        bus_write(A_TX, 32'h44);
        bus_write(A_TX, 32'h55);
        peek(A_ST, rd);
        check("tx_full_status", rd, 32'h0000_0005);
        peek(A_TX, rd);
        check("txdata_reads_zero", rd, 32'h0);
        bus_write(A_CTRL, 32'h1);
        expect_frame(8'h11);
        expect_frame(8'h22);
        expect_frame(8'h33);
        expect_frame(8'h44);
        tick();
        peek(A_ST, rd);
        check("tx_drained_status", rd, 32'h0000_0006);
        repeat (5) tick();
        check("fifth_byte_lost", 32'(tx), 32'd1);

        // Loopback of 0x3C
        bus_write(A_CTRL, 32'hF);
        bus_write(A_TX, 32'h3C);
        repeat (5) tick();
        check("loopback_tx_held", 32'(tx), 32'd1);
        repeat (40) tick();
        check("loopback_irq", 32'(irq), 32'd1);
        bus_read(A_RX, rd);
        check("loopback_rxdata", rd, 32'h0000_013C);
        check("loopback_irq_clear", 32'(irq), 32'd0);
        bus_read(A_RX, rd);
        check("loopback_rx_empty", rd, 32'h0);

        // Overrun: five frames into four entries
        bus_write(A_CTRL, 32'h6);
        uart_send(8'h81, 1'b1);
        uart_send(8'h42, 1'b1);
        uart_send(8'h24, 1'b1);
        uart_send(8'h18, 1'b1);
        uart_send(8'hE7, 1'b1);
        repeat (8) tick();
        peek(A_ST, rd);
        check("overrun_status", rd, 32'h0000_002A);
        check("overrun_irq", 32'(irq), 32'd1);
        bus_read(A_RX, rd);
        check("rx_byte0", rd, 32'h0000_0181);
        bus_read(A_RX, rd);
        check("rx_byte1", rd, 32'h0000_0142);
        bus_read(A_RX, rd);
        check("rx_byte2", rd, 32'h0000_0124);
        bus_read(A_RX, rd);
        check("rx_byte3", rd, 32'h0000_0118);
        bus_read(A_RX, rd);
        check("rx_after_drain", rd, 32'h0);
        peek(A_ST, rd);
        check("overrun_sticky", rd, 32'h0000_0026);

        // Framing error, then W1C of both flags
        uart_send(8'h5A, 1'b0);
        rx = 1'b1;
        repeat (8) tick();
        peek(A_ST, rd);
        check("frame_err_status", rd, 32'h0000_0066);
        bus_read(A_RX, rd);
        check("frame_err_no_byte", rd, 32'h0);
        bus_write(A_CTRL, 32'h66);
        peek(A_ST, rd);
        check("w1c_status", rd, 32'h0000_0006);
        check("w1c_irq", 32'(irq), 32'd0);
        peek(A_CTRL, rd);
        check("w1c_ctrl_readback", rd, 32'h0000_0006);

        // One-cycle glitch on rx
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (50) tick();
        peek(A_ST, rd);
        check("glitch_status", rd, 32'h0000_0006);
        check("glitch_irq", 32'(irq), 32'd0);
        bus_read(A_RX, rd);
        check("glitch_no_byte", rd, 32'h0);

        // Reset in the middle of a TX frame with one byte still queued
        bus_write(A_CTRL, 32'h1);
        bus_write(A_TX, 32'h00);
        bus_write(A_TX, 32'h00);
        repeat (10) tick();
        check("mid_frame_tx_low", 32'(tx), 32'd0);
        peek(A_ST, rd);
        check("mid_frame_status", rd, 32'h0000_0014);
        reset = 1'b0;
        tick();
        check("reset_tx_high", 32'(tx), 32'd1);
        peek(A_ST, rd);
        check("reset_status", rd, 32'h0000_0006);
        peek(A_CTRL, rd);
        check("reset_ctrl", rd, 32'h0);
        reset = 1'b1;
        repeat (5) tick();
        check("post_reset_tx_idle", 32'(tx), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
